// File: rtl/fifo_stream_out.sv
// Drains the flop FIFO read port into a valid/ready stream through a small skid buffer.
// Optional FIFO_STREAM_STALL_CNT_EN adds a saturating stall_cnt output.
module fifo_stream_out #(
  parameter int width   = 16,
  parameter int POP_LAT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [width-1:0] fifo_dout,
  input  logic             fifo_pndng,
  output logic             fifo_pop,
  output logic [width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             idle,
  output logic [CNT_W-1:0] word_cnt
`ifdef FIFO_STREAM_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);
  localparam int BUF_DEPTH = POP_LAT + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;

  // Storage sized for the deepest legal buffer; pointers wrap at BUF_DEPTH.
  logic [width-1:0] buf_q [4];
  logic [1:0]       rd_ptr, wr_ptr, occ, occ_nxt;
  logic             inflight, wr, xfer;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // Capacity check reserves room for the word still coming back from the FIFO.
  assign fifo_pop  = (state == RUN) && fifo_pndng &&
                     (({1'b0, occ} + {2'b0, inflight}) < 3'(BUF_DEPTH));
  assign wr        = (POP_LAT == 0) ? fifo_pop : inflight;
  assign out_valid = (occ != 2'd0);
  assign out_data  = buf_q[rd_ptr];
  assign xfer      = out_valid && out_ready;

  always_comb begin
    occ_nxt = occ;
    if (wr && !xfer)      occ_nxt = occ + 2'd1;
    else if (!wr && xfer) occ_nxt = occ - 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) buf_q[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= (POP_LAT == 1) && fifo_pop;
      if (wr) begin
        buf_q[wr_ptr] <= fifo_dout;
        wr_ptr        <= nxt(wr_ptr);
      end
      if (xfer) rd_ptr <= nxt(rd_ptr);
      occ <= occ_nxt;
    end
  end

  // DRAIN exits on the next-state occupancy so idle rises right after the last transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idle  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (enable) begin
          state <= RUN;
          idle  <= 1'b0;
        end
        RUN: if (!enable) state <= DRAIN;
        DRAIN: begin
          if (enable) state <= RUN;
          else if (occ_nxt == 2'd0 && !inflight) begin
            state <= IDLE;
            idle  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          idle  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      word_cnt <= '0;
    else if (xfer) word_cnt <= word_cnt + 1'b1;
  end

`ifdef FIFO_STREAM_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: doc/fifo_stream_out.md
Name: fifo_stream_out

Overview:
- Downstream drain stage for the flop FIFO.
- Pops words from the FIFO read side (Dout/pop/pndng) and presents them on a valid/ready stream with a small internal skid buffer, so full throughput is kept under backpressure.
- Provides an enable/drain control FSM and a delivered-word counter for the verification environment and for the next pipeline stage.

Parameters:
- width, 16, data word width; must match the FIFO `bits`.
- POP_LAT, 0, FIFO read latency in cycles from pop to valid Dout; legal values are 0 and 1.
- CNT_W, 16, width of the word and stall counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  1 = fetch from FIFO; 0 = stop fetching and drain.
- fifo_dout  in  width  FIFO read data.
- fifo_pndng  in  1  FIFO non-empty.
- fifo_pop  out  1  pop strobe to FIFO, one word per cycle high.
- out_data  out  width  stream data, head of skid buffer.
- out_valid  out  1  stream data valid.
- out_ready  in  1  downstream accepts when high with out_valid.
- idle  out  1  FSM in IDLE, no buffered or in-flight words.
- word_cnt  out  CNT_W  words delivered (valid && ready).
- stall_cnt  out  CNT_W  present only with STALL_CNT_EN.

Behaviour:
- Reset (rst=0, asynchronous): fifo_pop=0, out_valid=0, out_data=0, word_cnt=0, idle=1. Buffer is emptied, in-flight tracker cleared, FSM=IDLE. Any in-flight pop is discarded.
- Skid buffer: circular, BUF_DEPTH = POP_LAT+2 entries. Read/write pointers wrap modulo BUF_DEPTH. occ = number of entries held.
- inflight: 1-bit register, used only when POP_LAT=1. It is set in the cycle after fifo_pop and the word is written then. When POP_LAT=0, the word is written in the same cycle fifo_pop is high.
- Pop rule (registered terms only, no combinational path from out_ready): fifo_pop = (state==RUN) && fifo_pndng && (occ + inflight < BUF_DEPTH).
- Output: out_valid = (occ != 0). out_data = buffer[rd_ptr]. A transfer happens when out_valid && out_ready.
- Simultaneous write and transfer in one cycle: occ is unchanged and both pointers advance.
- While out_valid && !out_ready, out_data holds stable.
- Throughput: with out_ready held high and fifo_pndng held high, one word per cycle after initial latency of 1+POP_LAT cycles from the first pop to out_valid.
- Ordering: words leave in exact FIFO pop order; none are dropped or duplicated.
- FSM states:
  - IDLE: enable=1 -> RUN.
  - RUN: enable=0 -> DRAIN.
  - DRAIN: fifo_pop=0. enable=1 -> RUN. occ==0 && inflight==0 -> IDLE.
  - idle = (state==IDLE).
- Enable dropping in the same cycle as a pop: that pop completes and its word is buffered and delivered during DRAIN.
- word_cnt increments by 1 per transfer and wraps from 2^CNT_W-1 to 0.
- fifo_pndng low: no pop is issued; the stream continues emptying the buffer.
- The FIFO is never popped while empty. No pop is issued when the buffer plus in-flight words would exceed BUF_DEPTH.

Optional Feature:
- Macro: FIFO_STREAM_STALL_CNT_EN.
- Defined:
  - stall_cnt port exists.
  - It increments each cycle with out_valid && !out_ready and saturates at all-ones (no wrap).
  - Reset value 0.
- Undefined: the stall_cnt port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset and idle: rst=0 for 3 cycles mid-stream with occ=2 -> all outputs 0, idle=1, word_cnt=0. After rst=1, no pop until enable=1.
- Streaming, POP_LAT=0 and POP_LAT=1: push 8 words 0x0001..0x0008 into the FIFO, enable=1, out_ready=1.
  - Required: words out in order, back-to-back on 8 consecutive cycles, word_cnt=8.
  - First out_valid appears 1+POP_LAT cycles after the first pop.
- Backpressure: 8 words with out_ready=0 for 10 cycles.
  - Required: exactly BUF_DEPTH pops, then fifo_pop=0; out_data holds 0x0001.
  - After out_ready=1: remaining words delivered in order, none lost.
  - With the macro defined, stall_cnt=10.
- Drain: enable dropped while occ=2 and inflight=1 (POP_LAT=1).
  - Required: no further pops; 3 words delivered; idle=1 on the cycle after the last transfer.
- Empty FIFO: enable=1, fifo_pndng=0 for 20 cycles -> fifo_pop=0, out_valid=0, FSM stays RUN.
- Counter wrap: CNT_W=4, 17 transfers -> word_cnt=1.
